// File: rtl/common.sv
// common: bus request/response types shared by the fetch, memory and arbiter blocks.
package common;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} arb_state_t;
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;
  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } mem_req_t;
  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } mem_resp_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: fixed dbus priority with a starvation override for ibus.
module arb_pick (
  input  logic ivalid,
  input  logic dvalid,
  input  logic streak_at_limit,
  output logic grant_valid,
  output logic grant_is_d
);
  assign grant_valid = ivalid | dvalid;
  assign grant_is_d  = dvalid & ~(ivalid & streak_at_limit);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between ibus and dbus, one transaction at a time.
module mem_bus_arbiter
  import common::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ibus_req,
  output ibus_resp_t ibus_resp,
  input  dbus_req_t  dbus_req,
  output dbus_resp_t dbus_resp,
  output mem_req_t   mem_req,
  input  mem_resp_t  mem_resp,
  output logic       busy
);
  arb_state_t state, state_nx;
  logic owner_d, abort, grant_valid, grant_is_d, at_limit, done, deliver, abort_hit;
  logic [STREAK_W-1:0] streak;
  assign at_limit = streak == STREAK_W'(STARVE_LIMIT);
  arb_pick u_pick (
    .ivalid(ibus_req.valid),
    .dvalid(dbus_req.valid),
    .streak_at_limit(at_limit),
    .grant_valid(grant_valid),
    .grant_is_d(grant_is_d)
  );
  assign done = (state == S_ADDR && mem_resp.addr_ok && mem_resp.data_ok) ||
                (state == S_DATA && mem_resp.data_ok);
  assign busy      = state != S_IDLE;
  assign deliver   = done & ~abort;
  // a redirected fetch still lets memory finish but its response is dropped
  assign abort_hit = busy && !owner_d && (!ibus_req.valid || ibus_req.addr != mem_req.addr);
  assign ibus_resp = (deliver && !owner_d) ? ibus_resp_t'{1'b1, 1'b1, mem_resp.data} : '0;
  assign dbus_resp = (deliver && owner_d) ? dbus_resp_t'{1'b1, 1'b1, mem_resp.data} : '0;
  always_comb begin
    state_nx = done ? S_IDLE :
               (state == S_IDLE && grant_valid) ? S_ADDR :
               (state == S_ADDR && mem_resp.addr_ok) ? S_DATA : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req <= '0;
      owner_d <= 1'b0;
      streak  <= '0;
      abort   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (grant_valid) begin
        owner_d <= grant_is_d;
        mem_req <= grant_is_d ?
                   mem_req_t'{1'b1, dbus_req.is_write, dbus_req.addr, dbus_req.size, dbus_req.strobe, dbus_req.data} :
                   mem_req_t'{1'b1, 1'b0, ibus_req.addr, MSIZE4, '0, '0};
        streak  <= (grant_is_d && ibus_req.valid) ? streak + 1'b1 : '0;
      end
    end else if (done) begin
      mem_req.valid <= 1'b0;
      abort         <= 1'b0;
    end else begin
      if (state == S_ADDR && mem_resp.addr_ok) mem_req.valid <= 1'b0;
      if (abort_hit) abort <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios for the ibus/dbus memory arbiter.
module tb_mem_bus_arbiter;
  import common::*;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  ibus_req_t  ibus_req;
  ibus_resp_t ibus_resp;
  dbus_req_t  dbus_req;
  dbus_resp_t dbus_resp;
  mem_req_t   mem_req;
  mem_resp_t  mem_resp;
  logic       busy;
  int total = 0;
  int bad = 0;
  mem_bus_arbiter #(.STARVE_LIMIT(4), .STREAK_W(3)) dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_resp(ibus_resp),
    .dbus_req(dbus_req), .dbus_resp(dbus_resp),
    .mem_req(mem_req), .mem_resp(mem_resp),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic quiet();
    ibus_req = '0;
    dbus_req = '0;
    mem_resp = '0;
  endtask
  task automatic test_reset();
    quiet();
    rst = 1'b0;
    ibus_req.valid = 1'b1;
    ibus_req.addr  = 32'h8000_0000;
    dbus_req.valid = 1'b1;
    mem_resp = '{1'b1, 1'b1, 32'h1234};
    repeat (2) @(negedge clk);
    #1;
    total++; if (mem_req !== '0) begin bad++; $display("FAIL reset_mem_req got=%h want=0", mem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ibus_resp !== '0 || dbus_resp !== '0) begin bad++; $display("FAIL reset_resp got=%h/%h want=0", ibus_resp, dbus_resp); end
    quiet();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_ibus_single();
    ibus_req.valid = 1'b1;
    ibus_req.addr  = 32'h8000_0000;
    @(negedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t1_busy_c1 got=%b want=1", busy); end
    total++; if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h8000_0000 || mem_req.is_write !== 1'b0 || mem_req.size !== MSIZE4)
      begin bad++; $display("FAIL t1_mem_req got=%h want valid addr=80000000 rd word", mem_req); end
    total++; if (ibus_resp !== '0) begin bad++; $display("FAIL t1_resp_early got=%h want=0", ibus_resp); end
    @(negedge clk);
    mem_resp = '{1'b1, 1'b1, 32'h0000_0013};
    #1;
    total++; if (ibus_resp !== {1'b1, 1'b1, 32'h0000_0013}) begin bad++; $display("FAIL t1_resp got=%h want=3_00000013", ibus_resp); end
    total++; if (busy !== 1'b1 || dbus_resp !== '0) begin bad++; $display("FAIL t1_busy_c2 got=%b/%h want=1/0", busy, dbus_resp); end
    ibus_req.addr = 32'h8000_0004;
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0 || mem_req.valid !== 1'b0) begin bad++; $display("FAIL t1_bubble got busy=%b valid=%b want=0/0", busy, mem_req.valid); end
    total++; if (ibus_resp !== '0) begin bad++; $display("FAIL t1_resp_once got=%h want=0", ibus_resp); end
    @(negedge clk); #1;
    total++; if (busy !== 1'b1 || mem_req.addr !== 32'h8000_0004) begin bad++; $display("FAIL t1_regrant got busy=%b addr=%h want=1/80000004", busy, mem_req.addr); end
    mem_resp = '{1'b1, 1'b1, 32'h0000_0017};
    #1;
    total++; if (ibus_resp !== {1'b1, 1'b1, 32'h0000_0017}) begin bad++; $display("FAIL t1_resp2 got=%h want=3_00000017", ibus_resp); end
    ibus_req = '0;
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_end_busy got=%b want=0", busy); end
  endtask
  task automatic test_starvation();
    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int n = 0;
    logic is_d;
    ibus_req = '{1'b1, 32'h0000_2000};
    dbus_req = '{1'b1, 1'b1, 32'h0000_1000, MSIZE4, 4'hF, 32'h0000_0011};
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clk); #1;
      if (mem_req.valid) begin
        is_d = mem_req.addr == 32'h0000_1000;
        total++; if (is_d !== exp_d[n]) begin bad++; $display("FAIL starve_order grant%0d got_d=%b want_d=%b", n, is_d, exp_d[n]); end
        if (n == 4) begin
          total++; if (mem_req.is_write !== 1'b0 || mem_req.addr !== 32'h0000_2000 || mem_req.strobe !== 4'h0 || mem_req.size !== MSIZE4)
            begin bad++; $display("FAIL starve_ibus_req got=%h want rd 00002000 word strobe0", mem_req); end
        end
        n++;
        mem_resp = '{1'b1, 1'b1, 32'h0};
      end else mem_resp = '0;
    end
    total++; if (n != 6) begin bad++; $display("FAIL starve_grants got=%0d want=6", n); end
    ibus_req = '0;
    dbus_req = '0;
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL starve_end_busy got=%b want=0", busy); end
  endtask
  task automatic test_dbus_write();
    mem_req_t exp = '{1'b1, 1'b1, 32'h8000_1000, MSIZE4, 4'h0F, 32'hDEAD_BEEF};
    dbus_req = '{1'b1, 1'b1, 32'h8000_1000, MSIZE4, 4'h0F, 32'hDEAD_BEEF};
    @(negedge clk);
    mem_resp = '{1'b1, 1'b0, 32'h0};
    #1;
    total++; if (mem_req !== exp) begin bad++; $display("FAIL t3_mem_req got=%h want=%h", mem_req, exp); end
    total++; if (dbus_resp !== '0 || ibus_resp !== '0) begin bad++; $display("FAIL t3_resp_c1 got=%h/%h want=0", dbus_resp, ibus_resp); end
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      mem_resp = '0;
      dbus_req.data = 32'h0BAD_0000 + k;
      #1;
      total++; if (mem_req.valid !== 1'b0 || busy !== 1'b1 || dbus_resp !== '0)
        begin bad++; $display("FAIL t3_wait_c%0d got valid=%b busy=%b resp=%h want=0/1/0", k, mem_req.valid, busy, dbus_resp); end
    end
    @(negedge clk);
    mem_resp = '{1'b0, 1'b1, 32'h0000_0055};
    #1;
    total++; if (dbus_resp !== {1'b1, 1'b1, 32'h0000_0055}) begin bad++; $display("FAIL t3_resp got=%h want=3_00000055", dbus_resp); end
    total++; if (ibus_resp !== '0) begin bad++; $display("FAIL t3_ibus_zero got=%h want=0", ibus_resp); end
    dbus_req = '0;
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0 || dbus_resp !== '0) begin bad++; $display("FAIL t3_end got busy=%b resp=%h want=0/0", busy, dbus_resp); end
  endtask
  task automatic test_abort();
    ibus_req = '{1'b1, 32'h8000_0000};
    @(negedge clk);
    mem_resp = '{1'b1, 1'b0, 32'h0};
    @(negedge clk);
    mem_resp = '0;
    ibus_req.addr = 32'h8000_0100;
    #1;
    total++; if (ibus_resp !== '0 || busy !== 1'b1) begin bad++; $display("FAIL t4_data_wait got=%h busy=%b want=0/1", ibus_resp, busy); end
    @(negedge clk);
    mem_resp = '{1'b0, 1'b1, 32'h0000_00AA};
    #1;
    total++; if (ibus_resp !== '0) begin bad++; $display("FAIL t4_suppressed got=%h want=0", ibus_resp); end
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_bubble got=%b want=0", busy); end
    @(negedge clk); #1;
    total++; if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h8000_0100) begin bad++; $display("FAIL t4_new_addr got valid=%b addr=%h want=1/80000100", mem_req.valid, mem_req.addr); end
    mem_resp = '{1'b1, 1'b1, 32'h0000_00BB};
    #1;
    total++; if (ibus_resp !== {1'b1, 1'b1, 32'h0000_00BB}) begin bad++; $display("FAIL t4_new_resp got=%h want=3_000000bb", ibus_resp); end
    ibus_req = '0;
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_end_busy got=%b want=0", busy); end
  endtask
  task automatic test_async_reset();
    ibus_req = '{1'b1, 32'h0000_3000};
    dbus_req = '{1'b1, 1'b0, 32'h0000_4000, MSIZE4, 4'h0, 32'h0};
    @(negedge clk);
    mem_resp = '{1'b1, 1'b0, 32'h0};
    @(negedge clk);
    mem_resp = '{1'b0, 1'b1, 32'h0000_0099};
    #1;
    total++; if (dbus_resp !== {1'b1, 1'b1, 32'h0000_0099}) begin bad++; $display("FAIL t5_pre_resp got=%h want=3_00000099", dbus_resp); end
    total++; if (dut.streak !== 3'd1) begin bad++; $display("FAIL t5_pre_streak got=%0d want=1", dut.streak); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (mem_req.valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL t5_rst_state got valid=%b busy=%b want=0/0", mem_req.valid, busy); end
    total++; if (dbus_resp !== '0 || ibus_resp !== '0) begin bad++; $display("FAIL t5_rst_resp got=%h/%h want=0", dbus_resp, ibus_resp); end
    quiet();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (dut.streak !== 3'd0 || busy !== 1'b0) begin bad++; $display("FAIL t5_release got streak=%0d busy=%b want=0/0", dut.streak, busy); end
  endtask
  task automatic test_addr_hold();
    dbus_req = '{1'b1, 1'b0, 32'h0000_5000, MSIZE2, 4'h3, 32'h0};
    @(negedge clk); #1;
    total++; if (mem_req.addr !== 32'h0000_5000 || mem_req.size !== MSIZE2) begin bad++; $display("FAIL t6_latched got=%h want addr=00005000 half", mem_req); end
    dbus_req.addr = 32'h0000_6000;
    dbus_req.size = MSIZE8;
    @(negedge clk); #1;
    total++; if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h0000_5000 || mem_req.size !== MSIZE2)
      begin bad++; $display("FAIL t6_hold got valid=%b addr=%h want=1/00005000", mem_req.valid, mem_req.addr); end
    mem_resp = '{1'b1, 1'b1, 32'h0000_0077};
    #1;
    total++; if (dbus_resp !== {1'b1, 1'b1, 32'h0000_0077}) begin bad++; $display("FAIL t6_resp got=%h want=3_00000077", dbus_resp); end
    dbus_req = '0;
    @(negedge clk);
    mem_resp = '0;
    #1;
    total++; if (busy !== 1'b0 || mem_req.valid !== 1'b0) begin bad++; $display("FAIL t6_end got busy=%b valid=%b want=0/0", busy, mem_req.valid); end
  endtask
  initial begin
    quiet();
    test_reset();
    test_ibus_single();
    test_starvation();
    test_dbus_write();
    test_abort();
    test_async_reset();
    test_addr_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the fetch stage (ibus) and the memory stage (dbus).
- Grants at most one transaction at a time and holds a registered copy of the granted request on the memory side.
- Routes the memory response back to the owner only.
- dbus has priority; a streak counter bounds ibus starvation.
- Handles fetch redirects (abort) that occur mid-transaction.

Parameters:
- STARVE_LIMIT, 4: max consecutive dbus grants while ibus is pending; the next grant then goes to ibus.
- STREAK_W, 3: streak counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ibus_req  in  ibus_req_t  fetch request {valid, addr}
- ibus_resp  out  ibus_resp_t  fetch response {addr_ok, data_ok, data}
- dbus_req  in  dbus_req_t  data request {valid, is_write, addr, size, strobe, data}
- dbus_resp  out  dbus_resp_t  data response {addr_ok, data_ok, data}
- mem_req  out  mem_req_t  memory request {valid, is_write, addr, size, strobe, data}, registered
- mem_resp  in  mem_resp_t  memory response {addr_ok, data_ok, data}
- busy  out  1  high in any state except IDLE

Behaviour:
- State: IDLE, ADDR (mem_req.valid=1, waiting for mem addr_ok), DATA (mem_req.valid=0, waiting for mem data_ok).
- Registers: owner (I/D), latched request, streak, abort flag.
- Reset (rst=0, async): state=IDLE, mem_req all-zero, owner=I, streak=0, abort=0. ibus_resp and dbus_resp are all-zero whenever state=IDLE.
- IDLE arbitration, evaluated at each edge:
  - dbus only valid -> grant D.
  - ibus only valid -> grant I.
  - Both valid -> grant D unless streak==STARVE_LIMIT, then grant I.
- On grant: latch the request into mem_req (ibus grant: is_write=0, size=word, strobe=0); mem_req.valid=1; state=ADDR.
- Streak update on grant:
  - D grant with ibus valid -> streak+1.
  - Any I grant -> streak=0.
  - D grant with ibus idle -> streak=0.
- ADDR:
  - mem addr_ok & data_ok in the same cycle -> completion.
  - addr_ok only -> mem_req.valid=0, state=DATA.
- DATA: on mem data_ok -> completion.
- Completion cycle (combinational response):
  - Owner's resp gets addr_ok=data_ok=1 and data=mem_resp.data for exactly that cycle, unless abort=1.
  - Non-owner resp is all-zero at all times.
  - Next edge: state=IDLE, abort cleared.
- Mandatory one-cycle IDLE bubble after every completion, because requesters drop valid on the same edge. The same request is never re-granted.
- Minimum service time: 2 cycles per transaction (grant edge, completion edge, then IDLE).
- Abort (I owner only): in ADDR or DATA, if ibus_req.valid==0 or ibus_req.addr != latched addr, set abort=1.
  - The memory transaction still runs to completion; the response is suppressed (ibus addr_ok/data_ok stay 0).
  - The new fetch address is arbitrated normally in IDLE.
- dbus is never aborted. Changes to dbus_req while owner=D are ignored; the latched copy drives memory.
- mem_req fields are stable from grant until addr_ok.
- Reset asserted mid-transaction: return to IDLE immediately; no response emitted.

Decomposition:
- Package common:
  - ibus_req_t/ibus_resp_t exist already.
  - Add dbus_req_t, dbus_resp_t, mem_req_t, mem_resp_t, the msize_t enum (byte/half/word/dword), and the arbiter state enum.
- One sub-module: arb_pick. Combinational; inputs ivalid, dvalid, streak_at_limit; outputs grant_valid, grant_is_d.

Test Plan:
1. ibus only, addr 0x8000_0000; mem returns addr_ok and data_ok together with data 0x00000013 one cycle after valid -> ibus_resp addr_ok=data_ok=1, data=0x13 for exactly 1 cycle; busy for 2 cycles; next grant no earlier than one IDLE cycle later.
2. Both valid continuously (dbus re-requesting after each bubble), STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...; the 5th mem_req carries the ibus addr with is_write=0.
3. dbus write at addr 0x80001000, strobe 0x0F, data 0xDEADBEEF; mem gives addr_ok cycle 1, data_ok cycle 4 -> mem_req.valid drops after cycle 1; dbus_resp data_ok only at cycle 4; ibus_resp stays zero throughout.
4. ibus granted at 0x80000000, then ibus addr changes to 0x80000100 while in DATA -> no ibus data_ok for the old fetch; after the bubble, mem_req.addr=0x80000100 and that response is delivered.
5. rst driven low in DATA with owner=D, asynchronous to clk -> mem_req.valid=0, busy=0, both resp zero immediately; streak=0 after release.
6. Mid-transaction dbus_req.addr change (owner=D) -> mem_req.addr stays at the latched value until addr_ok.
